toycpu_seq: RTL and testbench
=============================

# toycpu_seq

Instruction sequencer for the toy CPU: fetches 16-bit instructions over a request/acknowledge memory port, decodes them, and drives the ALU opcode, register-file addresses and write strobe. It consumes the ALU's registered carry and zero flags for conditional branches. It sits between instruction memory and the ALU/register-file datapath. The ALU registers its flags every cycle, so this block must present the ADD opcode for exactly one cycle per ADD instruction.

## Interface
- PC_W, 8, program-counter and instruction-address width (1..8)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request, held until acknowledged
- imem_addr  out  PC_W  fetch address (= pc)
- imem_ack  in  1  memory acknowledge; imem_rdata valid in the same cycle
- imem_rdata  in  16  instruction word
- alu_op  out  4  ALU opcode: 4'h0 ADD, 4'hF MV (pass in1)
- cFlag  in  1  registered ALU carry flag
- zFlag  in  1  registered ALU zero flag
- rf_raddr1  out  4  register feeding ALU in1
- rf_raddr2  out  4  register feeding ALU in2
- rf_waddr  out  4  write-back register
- rf_we  out  1  register-file write strobe
- rf_wsel  out  1  write-data select: 0 ALU out, 1 imm
- imm  out  16  zero-extended imm8
- retire  out  1  one-cycle pulse per completed instruction
- halted  out  1  high while in HALT

## Operation
- Instruction fields: op=ir[15:12], rd=ir[11:8], rs=ir[7:4], imm8=ir[7:0].
- Opcodes:
  - 0 ADD rd,rs: rd <= rd+rs; the ALU updates C/Z.
  - 1 LDI rd,imm8: rd <= {8'h00,imm8}; flags unchanged.
  - 2 JMP imm8: pc <= target.
  - 3 JZ imm8: pc <= target if zFlag.
  - 4 JC imm8: pc <= target if cFlag.
  - 14 HALT (see Configuration).
  - 15 MV rd,rs: rd <= rs.
  - All other opcodes are NOP.
- target = imm8 truncated to PC_W bits; zero-extended if PC_W > 8 is ever permitted.
- States: FETCH, EXEC, HALT.
  - FETCH: imem_req=1, imem_addr=pc. On imem_ack, latch ir <= imem_rdata, set pc <= pc+1 (mod 2^PC_W), go to EXEC.
  - EXEC: one cycle. Drives the decoded outputs and asserts retire. Branches load pc. Next state is FETCH, or HALT for HALT.
  - HALT: absorbing. Only reset leaves it.
- Default outputs: alu_op=4'hF, rf_we=0, rf_wsel=0. alu_op=4'h0 only in EXEC of ADD, so flags never change outside an ADD.
- rf_raddr1 = rs for MV, else rd. rf_raddr2 = rs. rf_waddr = rd. imm = {8'h00, imm8}.
- rf_we=1 in EXEC for ADD, LDI, MV. rf_wsel=1 for LDI only.
- Branches read cFlag/zFlag in EXEC. These reflect all ADDs that retired before the branch, because the ALU registers flags on the EXEC edge of the ADD.
- imem_ack outside FETCH is ignored.

## Timing
- Reset (rst=0) values: state FETCH, pc=0, ir=0, imem_req=0, alu_op=4'hF, rf_we=0, rf_wsel=0, retire=0, halted=0.
- imem_req rises in the first cycle after reset deassertion.
- Instruction latency is (fetch wait + 1) + 1 cycles. With imem_ack tied high, that is 2 cycles per instruction.
- imem_req and imem_addr are stable from request until the ack cycle inclusive. imem_req drops in EXEC.
- Reset asserted mid-fetch or mid-EXEC: outputs take reset values immediately. No partial write completes, and a pending ack is discarded.
- pc wrap: fetch at 2^PC_W-1 continues at 0. A branch to the current address loops.
- In EXEC, the branch target overrides the incremented pc in the same edge.

## Configuration
- TOYCPU_HALT_EN defined: opcode 14 enters HALT. halted=1, imem_req=0, retire stays 0, and all outputs are held at defaults.
- TOYCPU_HALT_EN undefined: opcode 14 is a NOP. The HALT state and `halted` logic are absent, and `halted` is tied 0.

## Test plan
- Reset, imem_ack=1 with NOPs: imem_addr steps 0,1,2,… every 2 cycles. retire pulses in each EXEC. alu_op stays 4'hF throughout.
- LDI r1,0xFF; LDI r2,0x01; ADD r1,r2: rf_we/rf_wsel=1 with imm=16'h00FF, then 16'h0001. ADD EXEC shows alu_op=0 for exactly 1 cycle with raddr1=1, raddr2=2, waddr=1.
- JZ 0x20 with zFlag=1 → next imem_addr=0x20. JC 0x20 with cFlag=0 → next imem_addr=pc+1.
- imem_ack delayed 3 cycles: imem_req/imem_addr held for 4 cycles. Exactly one retire results. Spurious ack pulses in EXEC have no effect.
- pc=0xFF, PC_W=8, NOP → next fetch address 0x00. Assert rst mid-fetch → imem_req=0 asynchronously, and restart at address 0.
- Opcode 14: with TOYCPU_HALT_EN, halted=1 and no further imem_req. Without it, a fetch follows at pc+1.

Source files
------------

// File: rtl/toycpu_seq_if.sv
// Instruction-memory fetch port for the toy CPU sequencer.
//   imem_req   : fetch request, held until acknowledged
//   imem_addr  : fetch address (PC_W bits)
//   imem_ack   : memory acknowledge, imem_rdata valid in the same cycle
//   imem_rdata : 16-bit instruction word
// master = sequencer side, slave = memory side.
interface toycpu_seq_if #(
  parameter int unsigned PC_W = 8
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/toycpu_seq.sv
// Instruction sequencer for the toy CPU.
// Fetches 16-bit instructions over the imem request/acknowledge port,
// decodes them and drives the ALU opcode, register-file addresses and
// write strobe. Conditional branches consume the ALU's registered flags.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous, active-low reset
//   imem       : fetch port (toycpu_seq_if.master)
//   alu_op     : 4'h0 ADD, 4'hF MV (pass in1); 4'hF whenever idle
//   cFlag/zFlag: registered ALU carry / zero flags
//   rf_raddr1  : in1 register (rs for MV, else rd)
//   rf_raddr2  : in2 register (rs)
//   rf_waddr   : write-back register (rd)
//   rf_we      : write strobe (ADD, LDI, MV in EXEC)
//   rf_wsel    : write-data select, 0 ALU out, 1 imm (LDI)
//   imm        : zero-extended imm8
//   retire     : one-cycle pulse per completed instruction
//   halted     : high while in HALT
//
// Build option: define TOYCPU_HALT_EN to make opcode 14 enter an absorbing
// HALT state; otherwise opcode 14 is a NOP and halted is tied low.
module toycpu_seq #(
  parameter int unsigned PC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  toycpu_seq_if.master       imem,
  output logic [3:0]         alu_op,
  input  logic               cFlag,
  input  logic               zFlag,
  output logic [3:0]         rf_raddr1,
  output logic [3:0]         rf_raddr2,
  output logic [3:0]         rf_waddr,
  output logic               rf_we,
  output logic               rf_wsel,
  output logic [15:0]        imm,
  output logic               retire,
  output logic               halted
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1
`ifdef TOYCPU_HALT_EN
    ,
    HALT  = 2'd2
`endif
  } state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic [15:0]     ir, ir_nxt;

  logic [3:0] op, rd, rs;
  logic [7:0] imm8;
  logic [PC_W-1:0] target;

  assign op     = ir[15:12];
  assign rd     = ir[11:8];
  assign rs     = ir[7:4];
  assign imm8   = ir[7:0];
  assign target = PC_W'(imm8);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FETCH;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    ir_nxt        = ir;
    imem.imem_req = 1'b0;
    alu_op        = 4'hF;
    rf_we         = 1'b0;
    rf_wsel       = 1'b0;
    retire        = 1'b0;
    case (state)
      FETCH: begin
        // The reset state is FETCH, yet the request must read 0 while
        // reset is held, so it is qualified by the reset input itself.
        imem.imem_req = rst;
        if (imem.imem_ack) begin
          ir_nxt    = imem.imem_rdata;
          pc_nxt    = pc + PC_W'(1);
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        retire    = 1'b1;
        state_nxt = FETCH;
        case (op)
          4'h0: begin
            alu_op = 4'h0;
            rf_we  = 1'b1;
          end
          4'h1: begin
            rf_we   = 1'b1;
            rf_wsel = 1'b1;
          end
          4'h2: pc_nxt = target;
          4'h3: if (zFlag) pc_nxt = target;
          4'h4: if (cFlag) pc_nxt = target;
`ifdef TOYCPU_HALT_EN
          4'hE: state_nxt = HALT;
`endif
          4'hF: rf_we = 1'b1;
          default: ;
        endcase
      end
`ifdef TOYCPU_HALT_EN
      HALT: state_nxt = HALT;
`endif
      default: state_nxt = FETCH;
    endcase
  end

  assign imem.imem_addr = pc;
  assign rf_raddr1      = (op == 4'hF) ? rs : rd;
  assign rf_raddr2      = rs;
  assign rf_waddr       = rd;
  assign imm            = {8'h00, imm8};

`ifdef TOYCPU_HALT_EN
  assign halted = (state == HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_toycpu_seq.sv
module tb_toycpu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  alu_op;
  logic        cFlag = 1'b0;
  logic        zFlag = 1'b0;
  logic [3:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic        rf_we, rf_wsel;
  logic [15:0] imm;
  logic        retire, halted;

  int unsigned n_run  = 0;
  int unsigned n_fail = 0;

  toycpu_seq_if #(.PC_W(8)) imem ();

  toycpu_seq #(.PC_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .imem      (imem.master),
    .alu_op    (alu_op),
    .cFlag     (cFlag),
    .zFlag     (zFlag),
    .rf_raddr1 (rf_raddr1),
    .rf_raddr2 (rf_raddr2),
    .rf_waddr  (rf_waddr),
    .rf_we     (rf_we),
    .rf_wsel   (rf_wsel),
    .imm       (imm),
    .retire    (retire),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic [15:0] rdata;
    logic        c, z;
    logic        is_exec;
    logic [7:0]  addr;
    logic [3:0]  alu;
    logic        we, wsel;
    logic [3:0]  r1, r2, wa;
    logic [15:0] imm;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // FETCH-cycle vector: request up at addr, idle outputs
  task automatic fv(input logic [7:0] addr, input logic ack, input logic [15:0] rdata);
    vec_t v;
    v = '{ack: ack, rdata: rdata, c: 1'b0, z: 1'b0, is_exec: 1'b0, addr: addr,
          alu: 4'hF, we: 1'b0, wsel: 1'b0, r1: 4'h0, r2: 4'h0, wa: 4'h0, imm: 16'h0};
    vecs.push_back(v);
  endtask

  // EXEC-cycle vector: decoded outputs and retire pulse
  task automatic ev(input logic ack, input logic [15:0] rdata, input logic c, input logic z,
                    input logic [3:0] alu, input logic we, input logic wsel,
                    input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] wa,
                    input logic [15:0] im);
    vec_t v;
    v = '{ack: ack, rdata: rdata, c: c, z: z, is_exec: 1'b1, addr: 8'h00,
          alu: alu, we: we, wsel: wsel, r1: r1, r2: r2, wa: wa, imm: im};
    vecs.push_back(v);
  endtask

  initial begin
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = 16'h0000;

    // program: NOPs, LDI/LDI/ADD/MV, branches, delayed ack, pc wrap
    fv(8'h00, 1'b1, 16'h5000); ev(1'b0, 16'h0000, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0000);
    fv(8'h01, 1'b1, 16'h6123); ev(1'b0, 16'h0000, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 4'h1, 4'h2, 4'h1, 16'h0023);
    fv(8'h02, 1'b1, 16'h11FF); ev(1'b0, 16'h0000, 1'b0, 1'b0, 4'hF, 1'b1, 1'b1, 4'h1, 4'hF, 4'h1, 16'h00FF);
    fv(8'h03, 1'b1, 16'h1201); ev(1'b0, 16'h0000, 1'b0, 1'b0, 4'hF, 1'b1, 1'b1, 4'h2, 4'h0, 4'h2, 16'h0001);
    fv(8'h04, 1'b1, 16'h0120); ev(1'b1, 16'h1FFF, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h1, 4'h2, 4'h1, 16'h0020);
    fv(8'h05, 1'b1, 16'hF310); ev(1'b0, 16'h0000, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 4'h1, 4'h1, 4'h3, 16'h0010);
    fv(8'h06, 1'b1, 16'h3020); ev(1'b0, 16'h0000, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 4'h2, 4'h0, 16'h0020);
    fv(8'h20, 1'b1, 16'h4040); ev(1'b0, 16'h0000, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 4'h4, 4'h0, 16'h0040);
    fv(8'h21, 1'b1, 16'h4040); ev(1'b0, 16'h0000, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 4'h0, 4'h4, 4'h0, 16'h0040);
    fv(8'h40, 1'b1, 16'h2040); ev(1'b1, 16'h1234, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 4'h0, 4'h4, 4'h0, 16'h0040);
    fv(8'h40, 1'b0, 16'hFFFF);
    fv(8'h40, 1'b0, 16'hFFFF);
    fv(8'h40, 1'b0, 16'hFFFF);
    fv(8'h40, 1'b1, 16'h7000); ev(1'b0, 16'h0000, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0000);
    fv(8'h41, 1'b1, 16'h20FF); ev(1'b0, 16'h0000, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 4'h0, 4'hF, 4'h0, 16'h00FF);
    fv(8'hFF, 1'b1, 16'h8000); ev(1'b0, 16'h0000, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0000);
    fv(8'h00, 1'b1, 16'h9000); ev(1'b0, 16'h0000, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0000);

    // reset values
    #2;
    chk("rst_req",    {15'h0, imem.imem_req}, 16'h0);
    chk("rst_addr",   {8'h0, imem.imem_addr}, 16'h0);
    chk("rst_alu",    {12'h0, alu_op}, 16'h000F);
    chk("rst_we",     {15'h0, rf_we}, 16'h0);
    chk("rst_wsel",   {15'h0, rf_wsel}, 16'h0);
    chk("rst_retire", {15'h0, retire}, 16'h0);
    chk("rst_halted", {15'h0, halted}, 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      imem.imem_ack   = vecs[i].ack;
      imem.imem_rdata = vecs[i].rdata;
      cFlag           = vecs[i].c;
      zFlag           = vecs[i].z;
      #1;
      chk($sformatf("v%0d_req", i),    {15'h0, imem.imem_req}, {15'h0, ~vecs[i].is_exec});
      chk($sformatf("v%0d_retire", i), {15'h0, retire}, {15'h0, vecs[i].is_exec});
      chk($sformatf("v%0d_alu", i),    {12'h0, alu_op}, {12'h0, vecs[i].alu});
      chk($sformatf("v%0d_we", i),     {15'h0, rf_we}, {15'h0, vecs[i].we});
      chk($sformatf("v%0d_wsel", i),   {15'h0, rf_wsel}, {15'h0, vecs[i].wsel});
      chk($sformatf("v%0d_halted", i), {15'h0, halted}, 16'h0);
      if (vecs[i].is_exec) begin
        chk($sformatf("v%0d_raddr1", i), {12'h0, rf_raddr1}, {12'h0, vecs[i].r1});
        chk($sformatf("v%0d_raddr2", i), {12'h0, rf_raddr2}, {12'h0, vecs[i].r2});
        chk($sformatf("v%0d_waddr", i),  {12'h0, rf_waddr}, {12'h0, vecs[i].wa});
        chk($sformatf("v%0d_imm", i),    imm, vecs[i].imm);
      end else begin
        chk($sformatf("v%0d_addr", i), {8'h0, imem.imem_addr}, {8'h0, vecs[i].addr});
      end
    end

    // reset asserted mid-fetch at address 1 with an ack pending
    @(negedge clk);
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 16'h1355;
    cFlag = 1'b0;
    zFlag = 1'b0;
    #1;
    chk("mid_req_before",  {15'h0, imem.imem_req}, 16'h1);
    chk("mid_addr_before", {8'h0, imem.imem_addr}, 16'h0001);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_req_async",  {15'h0, imem.imem_req}, 16'h0);
    chk("mid_addr_async", {8'h0, imem.imem_addr}, 16'h0);
    chk("mid_we_async",   {15'h0, rf_we}, 16'h0);
    @(negedge clk);
    imem.imem_ack = 1'b0;
    rst = 1'b1;
    #1;
    chk("restart_req",    {15'h0, imem.imem_req}, 16'h1);
    chk("restart_addr",   {8'h0, imem.imem_addr}, 16'h0);
    chk("restart_retire", {15'h0, retire}, 16'h0);
    chk("restart_wsel",   {15'h0, rf_wsel}, 16'h0);

    // opcode 14 at address 0
    @(negedge clk);
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 16'hE000;
    #1;
    chk("op14_fetch_addr", {8'h0, imem.imem_addr}, 16'h0);
    @(negedge clk);
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 16'h0120;
    #1;
    chk("op14_retire", {15'h0, retire}, 16'h1);
    chk("op14_req",    {15'h0, imem.imem_req}, 16'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
`ifdef TOYCPU_HALT_EN
      chk("halt_halted", {15'h0, halted}, 16'h1);
      chk("halt_req",    {15'h0, imem.imem_req}, 16'h0);
      chk("halt_retire", {15'h0, retire}, 16'h0);
      chk("halt_alu",    {12'h0, alu_op}, 16'h000F);
      chk("halt_we",     {15'h0, rf_we}, 16'h0);
`else
      // ack held high: op14 acts as NOP, then 0120 (ADD) fetched at 1, 2, ...
      if (k == 0) begin
        chk("nohalt_req",    {15'h0, imem.imem_req}, 16'h1);
        chk("nohalt_addr",   {8'h0, imem.imem_addr}, 16'h0001);
        chk("nohalt_halted", {15'h0, halted}, 16'h0);
      end else if (k == 1) begin
        chk("nohalt_add_alu", {12'h0, alu_op}, 16'h0);
        chk("nohalt_retire",  {15'h0, retire}, 16'h1);
      end else begin
        chk("nohalt_addr2", {8'h0, imem.imem_addr}, 16'h0002);
        chk("nohalt_alu2",  {12'h0, alu_op}, 16'h000F);
      end
`endif
    end
    imem.imem_ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
